// File: rtl/rv32i_bus_arbiter_pkg.sv
// Shared types and constants for the two-master rv32i memory-port arbiter.
package rv32i_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  localparam logic        MST_M0 = 1'b0;
  localparam logic        MST_M1 = 1'b1;
  localparam int unsigned LAT_W  = 3;

  // A lock owner that is still requesting shuts the other master out; otherwise rr_ptr breaks ties.
  function automatic logic pick_owner(input logic req0, input logic req1,
                                      input logic lock_vld, input logic lock_own,
                                      input logic rr_ptr);
    logic sel;
    if (lock_vld && ((lock_own == MST_M1) ? req1 : req0)) sel = lock_own;
    else if (req0 && req1)                                 sel = rr_ptr;
    else                                                   sel = req1 ? MST_M1 : MST_M0;
    return sel;
  endfunction

endpackage

// File: rtl/rv32i_bus_arbiter.sv
// Round-robin arbiter sharing the single 16-bit memory port between rv32i_control (M0)
// and the loader/debug master (M1), with per-master lock and registered read return.
//
// state | meaning
// IDLE  | no owner; pick a requester and latch its fields
// ISSUE | one-cycle read/write strobe, illegal flag sampled
// WAIT  | read latency countdown, data captured on the last cycle
// ACK   | one-cycle completion pulse to the owner, lock/rr updated
module rv32i_bus_arbiter
  import rv32i_bus_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PORT_LEN     = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic                m0_lock_i,
  input  logic [XLEN-1:0]     m0_addr_i,
  input  logic [PORT_LEN-1:0] m0_wdata_i,
  input  logic [PORT_LEN-1:0] m0_wmask_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [PORT_LEN-1:0] m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic                m1_lock_i,
  input  logic [XLEN-1:0]     m1_addr_i,
  input  logic [PORT_LEN-1:0] m1_wdata_i,
  input  logic [PORT_LEN-1:0] m1_wmask_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [PORT_LEN-1:0] m1_rdata_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [PORT_LEN-1:0] mem_data_o,
  output logic [PORT_LEN-1:0] mem_mask_o,
  input  logic [PORT_LEN-1:0] mem_data_i,
  input  logic                mem_illegal_i,
  output logic [1:0]          grant_o
);

  arb_state_e          state_q, state_d;
  logic                owner_q, rr_q, lock_vld_q, lock_own_q, we_q, err_q;
  logic [XLEN-1:0]     addr_q;
  logic [PORT_LEN-1:0] wdata_q, wmask_q, m0_rdata_q, m1_rdata_q;
  logic [LAT_W-1:0]    cnt_q;
  logic                any_req, pick, lock_still_req, owner_lock;

  assign any_req        = m0_req_i | m1_req_i;
  assign lock_still_req = (lock_own_q == MST_M1) ? m1_req_i : m0_req_i;
  assign owner_lock     = (owner_q == MST_M1) ? m1_lock_i : m0_lock_i;
  assign pick           = pick_owner(m0_req_i, m1_req_i, lock_vld_q, lock_own_q, rr_q);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    grant_o     = 2'b00;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: begin
        mem_read_o  = ~we_q;
        mem_write_o = we_q;
        state_d     = we_q ? ST_ACK : ST_WAIT;
      end
      ST_WAIT:  if (cnt_q == LAT_W'(1)) state_d = ST_ACK;
      ST_ACK: begin
        m0_ack_o = (owner_q == MST_M0);
        m1_ack_o = (owner_q == MST_M1);
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) grant_o = (owner_q == MST_M1) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      owner_q    <= MST_M0;
      rr_q       <= MST_M0;
      lock_vld_q <= 1'b0;
      lock_own_q <= MST_M0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Lock holder that stopped requesting gives the bus up; pick already ignores it.
          if (lock_vld_q && !lock_still_req) lock_vld_q <= 1'b0;
          if (any_req) begin
            owner_q <= pick;
            we_q    <= (pick == MST_M1) ? m1_we_i    : m0_we_i;
            addr_q  <= (pick == MST_M1) ? m1_addr_i  : m0_addr_i;
            wdata_q <= (pick == MST_M1) ? m1_wdata_i : m0_wdata_i;
            wmask_q <= (pick == MST_M1) ? m1_wmask_i : m0_wmask_i;
          end
        end
        ST_ISSUE: begin
          err_q <= mem_illegal_i;
          cnt_q <= LAT_W'(READ_LATENCY);
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            if (owner_q == MST_M1) m1_rdata_q <= err_q ? '0 : mem_data_i;
            else                   m0_rdata_q <= err_q ? '0 : mem_data_i;
          end
        end
        ST_ACK: begin
          if (owner_lock) begin
            lock_vld_q <= 1'b1;
            lock_own_q <= owner_q;
          end else begin
            lock_vld_q <= 1'b0;
            rr_q       <= ~owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign mem_mask_o = wmask_q;
  assign m0_err_o   = m0_ack_o & err_q;
  assign m1_err_o   = m1_ack_o & err_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;

  // Owner must hold its request until the ack; a dropped request still completes.
  always @(posedge clk_i) begin
    if (reset_ni && (state_q == ST_ISSUE || state_q == ST_WAIT))
      assert ((owner_q == MST_M1) ? m1_req_i : m0_req_i);
  end

endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Self-checking bench for rv32i_bus_arbiter: directed scenarios plus randomized two-master traffic.
module tb_rv32i_bus_arbiter;
  localparam int RL = 1;

  typedef struct {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] wmask;
    int          start;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [1:0]  req_v, we_v, lock_v;
  logic [31:0] addr_v [2];
  logic [15:0] wdata_v [2];
  logic [15:0] wmask_v [2];
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write, mem_illegal;
  logic [15:0] mem_data_o, mem_mask, mem_data_i;
  logic [1:0]  grant;
  logic [1:0]  ack_v, err_v;
  logic [15:0] rdata_v [2];

  assign ack_v      = {m1_ack, m0_ack};
  assign err_v      = {m1_err, m0_err};
  assign rdata_v[0] = m0_rdata;
  assign rdata_v[1] = m1_rdata;

  rv32i_bus_arbiter #(.XLEN(32), .PORT_LEN(16), .READ_LATENCY(RL)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m0_req_i(req_v[0]), .m0_we_i(we_v[0]), .m0_lock_i(lock_v[0]), .m0_addr_i(addr_v[0]),
    .m0_wdata_i(wdata_v[0]), .m0_wmask_i(wmask_v[0]),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(req_v[1]), .m1_we_i(we_v[1]), .m1_lock_i(lock_v[1]), .m1_addr_i(addr_v[1]),
    .m1_wdata_i(wdata_v[1]), .m1_wmask_i(wmask_v[1]),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask), .mem_data_i(mem_data_i),
    .mem_illegal_i(mem_illegal), .grant_o(grant)
  );

  always #5 clk_i = ~clk_i;

  // Address map shared by memory environment and reference: >= 0x3000 is illegal, unwritten words read a pattern.
  function automatic logic [15:0] dflt(input logic [31:0] a);
    return a[15:0] ^ 16'h1234;
  endfunction
  function automatic logic is_illegal(input logic [31:0] a);
    return a >= 32'h3000;
  endfunction

  // Memory environment: registered read data valid only in the cycle after the strobe.
  bit          env_vld [8192];
  logic [15:0] env_mem [8192];
  logic [15:0] rd_q;
  function automatic logic [15:0] env_rd(input logic [31:0] a);
    return env_vld[a[13:1]] ? env_mem[a[13:1]] : dflt(a);
  endfunction
  always_ff @(posedge clk_i) begin
    if (mem_write && !mem_illegal) begin
      env_vld[mem_addr[13:1]] <= 1'b1;
      env_mem[mem_addr[13:1]] <= (env_rd(mem_addr) & ~mem_mask) | (mem_data_o & mem_mask);
    end
    rd_q <= mem_read ? env_rd(mem_addr) : 16'hDEAD;
  end
  assign mem_data_i  = rd_q;
  assign mem_illegal = is_illegal(mem_addr);

  // Transaction-level reference: memory contents as seen by completed writes.
  bit          ref_vld [8192];
  logic [15:0] ref_mem [8192];
  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    return ref_vld[a[13:1]] ? ref_mem[a[13:1]] : dflt(a);
  endfunction

  txn_t        q [2][$];
  bit          started [2];
  int          pres [2];
  logic [15:0] exp_rdata [2];
  int          ack_log [$];
  int          cyc, lat_mode;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acked [2];
    txn_t t;
    int own, lat;
    logic [15:0] nv;
    @(posedge clk_i); #1;
    cyc++;
    if (mem_read || mem_write) begin
      check("grant_onehot", 32'($onehot(grant)), 32'd1);
      own = grant[1] ? 1 : 0;
      check($sformatf("strobe_owner_pending_m%0d", own), 32'(q[own].size() > 0 && started[own]), 32'd1);
      if (q[own].size() > 0) begin
        t = q[own][0];
        check("strobe_kind", {30'd0, mem_write, mem_read}, t.we ? 32'd2 : 32'd1);
        check("mem_addr", mem_addr, t.addr);
        if (t.we) begin
          check("mem_wdata", 32'(mem_data_o), 32'(t.wdata));
          check("mem_wmask", 32'(mem_mask), 32'(t.wmask));
        end
      end
    end
    if (ack_v != 2'b00) check("ack_exclusive", 32'(&ack_v), 32'd0);
    for (int m = 0; m < 2; m++) begin
      acked[m] = ack_v[m];
      if (ack_v[m]) begin
        if (q[m].size() == 0) check($sformatf("spurious_ack_m%0d", m), 32'(ack_v[m]), 32'd0);
        else begin
          t = q[m].pop_front();
          if (!t.we) exp_rdata[m] = is_illegal(t.addr) ? 16'h0000 : ref_rd(t.addr);
          else if (!is_illegal(t.addr)) begin
            nv = (ref_rd(t.addr) & ~t.wmask) | (t.wdata & t.wmask);
            ref_vld[t.addr[13:1]] = 1'b1;
            ref_mem[t.addr[13:1]] = nv;
          end
          check($sformatf("err_m%0d@%0h", m, t.addr), 32'(err_v[m]), 32'(is_illegal(t.addr)));
          check($sformatf("rdata_m%0d@%0h", m, t.addr), 32'(rdata_v[m]), 32'(exp_rdata[m]));
          lat = cyc - pres[m];
          if (lat_mode == 1) check($sformatf("latency_m%0d", m), 32'(lat), t.we ? 32'd2 : 32'(2 + RL));
          if (lat_mode == 2) check($sformatf("latency_bound_m%0d", m), 32'(lat <= 7), 32'd1);
          ack_log.push_back(m);
          started[m] = 1'b0;
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (!acked[m]) begin
        if (q[m].size() > 0 && cyc >= q[m][0].start) begin
          req_v[m]   = 1'b1;
          we_v[m]    = q[m][0].we;
          lock_v[m]  = q[m][0].lock;
          addr_v[m]  = q[m][0].addr;
          wdata_v[m] = q[m][0].wdata;
          wmask_v[m] = q[m][0].wmask;
          if (!started[m]) begin
            started[m] = 1'b1;
            pres[m]    = cyc;
          end
        end else begin
          req_v[m]  = 1'b0;
          lock_v[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int max_cyc);
    int n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_in_time", 32'(q[0].size() + q[1].size()), 32'd0);
    q[0].delete();
    q[1].delete();
    step();
  endtask

  task automatic clear_masters();
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      started[m]   = 1'b0;
      exp_rdata[m] = 16'h0000;
      req_v[m]     = 1'b0;
      we_v[m]      = 1'b0;
      lock_v[m]    = 1'b0;
      addr_v[m]    = '0;
      wdata_v[m]   = '0;
      wmask_v[m]   = '0;
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    clear_masters();
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
  endtask

  function automatic txn_t mk(input logic we, input logic lock, input logic [31:0] a,
                              input logic [15:0] d, input logic [15:0] msk, input int st);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = a; t.wdata = d; t.wmask = msk; t.start = st;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1;
    int exp_alt [8];
    logic [31:0] ra;
    n_tests = 0; n_fail = 0; cyc = 0; lat_mode = 1;

    // Reset values
    reset_ni = 1'b0;
    clear_masters();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_acks", 32'(ack_v), 32'd0);
    check("rst_errs", 32'(err_v), 32'd0);
    check("rst_rdata_m0", 32'(m0_rdata), 32'd0);
    check("rst_rdata_m1", 32'(m1_rdata), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", 32'(mem_data_o), 32'd0);
    check("rst_mem_mask", 32'(mem_mask), 32'd0);
    reset_ni = 1'b1;

    // Solo M0 read of ROM word, M1 write + readback, M1 illegal read
    lat_mode = 1;
    q[0].push_back(mk(1'b0, 1'b0, 32'h0000, 16'h0, 16'h0, cyc));
    run(20);
    check("m0_rom_read", 32'(m0_rdata), 32'h1234);
    q[1].push_back(mk(1'b1, 1'b0, 32'h0400, 16'hBEEF, 16'hFFFF, cyc));
    q[1].push_back(mk(1'b0, 1'b0, 32'h0400, 16'h0, 16'h0, cyc));
    run(20);
    check("m1_readback", 32'(m1_rdata), 32'hBEEF);
    q[1].push_back(mk(1'b0, 1'b0, 32'h3000, 16'h0, 16'h0, cyc));
    run(20);
    check("m1_illegal_rdata", 32'(m1_rdata), 32'h0);

    // Both requesting from reset: strict alternation
    do_reset();
    lat_mode = 2;
    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(mk(1'b0, 1'b0, 32'h0100 + 32'(4 * i), 16'h0, 16'h0, cyc));
      q[1].push_back(mk(1'b0, 1'b0, 32'h0102 + 32'(4 * i), 16'h0, 16'h0, cyc));
    end
    run(60);
    exp_alt = '{0, 1, 0, 1, 0, 1, 0, 1};
    check("alt_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      check($sformatf("alt_order_%0d", i), 32'(ack_log[i]), 32'(exp_alt[i]));

    // M0 locked pair of reads keeps M1 out until the second ack
    lat_mode = 0;
    ack_log.delete();
    q[0].push_back(mk(1'b0, 1'b1, 32'h0400, 16'h0, 16'h0, cyc));
    q[0].push_back(mk(1'b0, 1'b0, 32'h0402, 16'h0, 16'h0, cyc));
    q[1].push_back(mk(1'b0, 1'b0, 32'h0404, 16'h0, 16'h0, cyc + 2));
    run(40);
    check("lock_count", 32'(ack_log.size()), 32'd3);
    if (ack_log.size() == 3) begin
      check("lock_first", 32'(ack_log[0]), 32'd0);
      check("lock_second", 32'(ack_log[1]), 32'd0);
      check("lock_third", 32'(ack_log[2]), 32'd1);
    end
    check("lock_m0_data", 32'(m0_rdata), 32'(dflt(32'h0402)));

    // Async reset while M1 read is in WAIT
    lat_mode = 0;
    q[1].push_back(mk(1'b0, 1'b0, 32'h0010, 16'h0, 16'h0, cyc));
    step(); step(); step();
    check("pre_reset_in_wait", {30'd0, mem_read, |grant}, 32'd1);
    reset_ni = 1'b0;
    #1;
    check("async_rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("async_rst_acks", 32'(ack_v), 32'd0);
    check("async_rst_grant", 32'(grant), 32'd0);
    clear_masters();
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    check("post_rst_m1_rdata", 32'(m1_rdata), 32'd0);
    lat_mode = 1;
    q[0].push_back(mk(1'b0, 1'b0, 32'h0000, 16'h0, 16'h0, cyc));
    run(20);
    check("post_rst_m0_read", 32'(m0_rdata), 32'h1234);

    // Randomized two-master traffic against the reference memory
    lat_mode = 2;
    s0 = cyc; s1 = cyc;
    for (int i = 0; i < 30; i++) begin
      for (int m = 0; m < 2; m++) begin
        ra = ($urandom_range(0, 7) == 0) ? 32'h3000 + 32'(2 * $urandom_range(0, 15))
                                         : 32'h0200 + 32'(2 * $urandom_range(0, 15));
        if (m == 0) s0 += $urandom_range(0, 4);
        else        s1 += $urandom_range(0, 4);
        q[m].push_back(mk(1'($urandom_range(0, 1)), 1'b0, ra, 16'($urandom), 16'($urandom),
                          (m == 0) ? s0 : s1));
      end
    end
    run(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
